// File: rtl/div_n_serial.sv
// rtl/div_n_serial.sv - serial divisibility checker: running remainder of a bit stream mod DIVISOR
module div_n_serial #(
    parameter int DIVISOR = 5,
    parameter int CNT_W   = 8,
    localparam int RW     = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             inp,
    input  logic             lsb_first,
    output logic             out,
    output logic [RW-1:0]    rem,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [RW:0]   DIV_EXT = (RW + 1)'(DIVISOR);
    localparam logic [RW-1:0] W_ONE   = RW'(1);

    logic [RW-1:0]    rem_q;
    logic [RW-1:0]    w_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;

    logic [RW-1:0]    base_rem;
    logic [RW-1:0]    base_w;
    logic [CNT_W-1:0] base_cnt;
    logic             mode_eff;
    logic [RW:0]      msb_sum;
    logic [RW:0]      lsb_sum;
    logic [RW:0]      w_dbl;
    logic [RW-1:0]    nxt_rem;
    logic [RW-1:0]    nxt_w;
    logic [CNT_W-1:0] nxt_cnt;

    // Every operand is below 2*DIVISOR, so one conditional subtract is a full mod.
    function automatic logic [RW-1:0] mod_once(input logic [RW:0] x);
        logic [RW:0] t;
        t = (x >= DIV_EXT) ? (x - DIV_EXT) : x;
        return t[RW-1:0];
    endfunction

    always_comb begin
        // clr with a valid bit starts the new number from the empty state
        base_rem = clr ? '0    : rem_q;
        base_w   = clr ? W_ONE : w_q;
        base_cnt = clr ? '0    : cnt_q;
        mode_eff = (base_cnt == '0) ? lsb_first : mode_q;

        msb_sum  = {base_rem, 1'b0} + {{RW{1'b0}}, inp};
        lsb_sum  = {1'b0, base_rem} + (inp ? {1'b0, base_w} : '0);
        w_dbl    = {base_w, 1'b0};

        nxt_rem  = mode_eff ? mod_once(lsb_sum) : mod_once(msb_sum);
        nxt_w    = mod_once(w_dbl);
        nxt_cnt  = (&base_cnt) ? base_cnt : base_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            w_q    <= W_ONE;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else if (in_valid) begin
            rem_q  <= nxt_rem;
            w_q    <= nxt_w;
            cnt_q  <= nxt_cnt;
            mode_q <= mode_eff;
        end else if (clr) begin
            rem_q  <= '0;
            w_q    <= W_ONE;
            cnt_q  <= '0;
        end
    end

    assign rem     = rem_q;
    assign bit_cnt = cnt_q;
    assign out     = (rem_q == '0);

endmodule

// File: tb/tb_div_n_serial.sv
// tb/tb_div_n_serial.sv - directed vector bench for div_n_serial at DIVISOR 5 and 3
module tb_div_n_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       clr5 = 0, vld5 = 0, inp5 = 0, lsb5 = 0;
    logic       out5;
    logic [2:0] rem5;
    logic [7:0] cnt5;

    logic       clr3 = 0, vld3 = 0, inp3 = 0, lsb3 = 0;
    logic       out3;
    logic [1:0] rem3;
    logic [2:0] cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    div_n_serial #(.DIVISOR(5), .CNT_W(8)) dut5 (
        .clk(clk), .rst(rst), .clr(clr5), .in_valid(vld5), .inp(inp5),
        .lsb_first(lsb5), .out(out5), .rem(rem5), .bit_cnt(cnt5)
    );

    div_n_serial #(.DIVISOR(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .clr(clr3), .in_valid(vld3), .inp(inp3),
        .lsb_first(lsb3), .out(out3), .rem(rem3), .bit_cnt(cnt3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   d;
        logic clr;
        logic vld;
        logic inp;
        logic lsb;
        int   rem;
        logic out;
        int   cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int d, input logic c, input logic v, input logic i,
                       input logic l, input int r, input logic o, input int n);
        vec_t x;
        x.d = d; x.clr = c; x.vld = v; x.inp = i; x.lsb = l;
        x.rem = r; x.out = o; x.cnt = n;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check5(input string tag, input int r, input logic o, input int n);
        check({tag, "_rem"}, int'(rem5), r);
        check({tag, "_out"}, int'(out5), int'(o));
        check({tag, "_cnt"}, int'(cnt5), n);
    endtask

    task automatic check3(input string tag, input int r, input logic o, input int n);
        check({tag, "_rem"}, int'(rem3), r);
        check({tag, "_out"}, int'(out3), int'(o));
        check({tag, "_cnt"}, int'(cnt3), n);
    endtask

    task automatic step(input int d, input logic c, input logic v, input logic i, input logic l);
        clr5 = 0; vld5 = 0; inp5 = 0; lsb5 = 0;
        clr3 = 0; vld3 = 0; inp3 = 0; lsb3 = 0;
        if (d == 5) begin
            clr5 = c; vld5 = v; inp5 = i; lsb5 = l;
        end else begin
            clr3 = c; vld3 = v; inp3 = i; lsb3 = l;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // MSB-first 1,0,1,0 = 10
        add(5, 0, 1, 1, 0, 1, 0, 1);
        add(5, 0, 1, 0, 0, 2, 0, 2);
        add(5, 0, 1, 1, 0, 0, 1, 3);
        add(5, 0, 1, 0, 0, 0, 1, 4);
        add(5, 1, 0, 0, 0, 0, 1, 0);
        // LSB-first 1,1,1,1 = 15, then an idle cycle
        add(5, 0, 1, 1, 1, 1, 0, 1);
        add(5, 0, 1, 1, 0, 3, 0, 2);
        add(5, 0, 1, 1, 0, 2, 0, 3);
        add(5, 0, 1, 1, 0, 0, 1, 4);
        add(5, 0, 0, 1, 0, 0, 1, 4);
        add(5, 1, 0, 0, 0, 0, 1, 0);
        // three MSB bits, then clr with a valid 1 restarts the number
        add(5, 0, 1, 1, 0, 1, 0, 1);
        add(5, 0, 1, 1, 0, 3, 0, 2);
        add(5, 0, 1, 0, 0, 1, 0, 3);
        add(5, 1, 1, 1, 0, 1, 0, 1);
        // lsb_first toggles mid-number; still MSB-first 11101 = 29
        add(5, 0, 1, 1, 1, 3, 0, 2);
        add(5, 0, 1, 1, 1, 2, 0, 3);
        add(5, 0, 1, 0, 0, 4, 0, 4);
        add(5, 0, 1, 1, 1, 4, 0, 5);
        // DIVISOR 3 with a gap: 1,(gap),1,0
        add(3, 0, 1, 1, 0, 1, 0, 1);
        add(3, 0, 0, 0, 0, 1, 0, 1);
        add(3, 0, 1, 1, 0, 0, 1, 2);
        add(3, 0, 1, 0, 0, 0, 1, 3);
        // counter saturates at 7 while the remainder keeps moving
        add(3, 0, 1, 1, 0, 1, 0, 4);
        add(3, 0, 1, 1, 0, 0, 1, 5);
        add(3, 0, 1, 1, 0, 1, 0, 6);
        add(3, 0, 1, 1, 0, 0, 1, 7);
        add(3, 0, 1, 1, 0, 1, 0, 7);
        add(3, 0, 1, 1, 0, 0, 1, 7);

        #3;
        check5("reset5", 0, 1'b1, 0);
        check3("reset3", 0, 1'b1, 0);
        @(negedge clk);
        rst = 0;

        foreach (vecs[k]) begin
            step(vecs[k].d, vecs[k].clr, vecs[k].vld, vecs[k].inp, vecs[k].lsb);
            if (vecs[k].d == 5)
                check5($sformatf("v%0d", k), vecs[k].rem, vecs[k].out, vecs[k].cnt);
            else
                check3($sformatf("v%0d", k), vecs[k].rem, vecs[k].out, vecs[k].cnt);
        end

        // asynchronous reset mid-number, between edges
        step(5, 1, 0, 0, 0);
        step(5, 0, 1, 1, 0);
        step(5, 0, 1, 1, 0);
        check5("pre_rst", 3, 1'b0, 2);
        #3;
        rst = 1;
        #1;
        check5("async_rst", 0, 1'b1, 0);
        #1;
        rst = 0;
        check5("rst_release", 0, 1'b1, 0);
        step(5, 0, 1, 1, 0);
        check5("resume", 1, 1'b0, 1);

        // rst dominates clr and in_valid at a clock edge
        vld5 = 1; inp5 = 1; clr5 = 1;
        rst = 1;
        @(posedge clk);
        #1;
        check5("rst_dom", 0, 1'b1, 0);
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
